// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: base opcodes, immediate format codes and the
// reset/NOP instruction word. The opcode values are the same ones the
// multicycle control unit's next-state logic decodes.
package rv32_pkg;

  // Base RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Immediate format codes as presented on imm_fmt
  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_fmt_e;

  // addi x0,x0,0 -- the IR holds this after reset so the control unit
  // sees a harmless, legal instruction before the first fetch.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Map a major opcode to its immediate format; unknown opcodes map to R
  // (the caller flags them illegal separately).
  function automatic imm_fmt_e fmt_of_op(input logic [6:0] op);
    imm_fmt_e f;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: f = IMM_I;
      OP_STORE:                            f = IMM_S;
      OP_BRANCH:                           f = IMM_B;
      OP_LUI, OP_AUIPC:                    f = IMM_U;
      OP_JAL:                              f = IMM_J;
      default:                             f = IMM_R;
    endcase
    return f;
  endfunction

  // True when op is one of the ten RV32I base opcodes. All of them end in
  // 2'b11, so a non-11 low pair falls out as illegal automatically.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: classifies the instruction word by
// opcode, produces the sign-extended immediate, the format code and an
// illegal-opcode indication. Sign bit is always instr[31].
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_fmt,
  output logic            o_illegal
);

  logic [6:0]      w_op;
  logic            w_sign;
  logic            w_legal;
  imm_fmt_e        w_fmt;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_op    = i_instr[6:0];
  assign w_sign  = i_instr[31];
  assign w_legal = is_legal_op(w_op);

  // Candidate immediates for every format, all sign-extended from bit 31
  assign w_imm_i = {{(XLEN-12){w_sign}}, i_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){w_sign}}, i_instr[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

  // Illegal words report R format so downstream never sees a stale
  // immediate attached to garbage.
  always_comb begin
    w_fmt = IMM_R;
    if (w_legal) begin
      w_fmt = fmt_of_op(w_op);
    end
  end

  // Select the immediate matching the decoded format
  always_comb begin
    o_imm = '0;
    case (w_fmt)
      IMM_I:   o_imm = w_imm_i;
      IMM_S:   o_imm = w_imm_s;
      IMM_B:   o_imm = w_imm_b;
      IMM_U:   o_imm = w_imm_u;
      IMM_J:   o_imm = w_imm_j;
      default: o_imm = '0;
    endcase
  end

  assign o_imm_fmt = w_fmt;
  assign o_illegal = ~w_legal;

endmodule

// File: rtl/instr_reg_decode.sv
// Instruction Register / Memory Data Register stage of the multicycle RV32I
// datapath. Holds IR and MDR, decodes IR fields combinationally, keeps a
// sticky illegal-opcode flag and counts IR loads.
module instr_reg_decode
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ir_write,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             illegal_clr,
  output logic [XLEN-1:0]  mdr,
  output logic [6:0]       op,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       imm_fmt,
  output logic             illegal,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  r_ir;
  logic [XLEN-1:0]  r_mdr;
  logic             r_ill_sticky;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic             w_illegal;

  // IR loads on IRWrite only; reset parks it on a NOP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= XLEN'(INSTR_NOP);
    end else if (ir_write) begin
      r_ir <= mem_rdata;
    end
  end

  // MDR captures the memory bus every cycle, no enable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdr <= '0;
    end else begin
      r_mdr <= mem_rdata;
    end
  end

  // Fetch counter: one per IR load, wraps silently
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
    end else if (ir_write) begin
      r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
    end
  end

  // Sticky illegal flag samples the IR held before the edge; set beats clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ill_sticky <= 1'b0;
    end else if (w_illegal) begin
      r_ill_sticky <= 1'b1;
    end else if (illegal_clr) begin
      r_ill_sticky <= 1'b0;
    end
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr   (r_ir),
    .o_imm     (imm),
    .o_imm_fmt (imm_fmt),
    .o_illegal (w_illegal)
  );

  assign op             = r_ir[6:0];
  assign rd             = r_ir[11:7];
  assign funct3         = r_ir[14:12];
  assign rs1            = r_ir[19:15];
  assign rs2            = r_ir[24:20];
  assign funct7         = r_ir[31:25];
  assign illegal        = w_illegal;
  assign illegal_sticky = r_ill_sticky;
  assign mdr            = r_mdr;
  assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_instr_reg_decode.sv
// Directed bench for instr_reg_decode: a table of instruction words with
// hand-decoded fields, followed by hold/MDR, sticky-flag and counter-wrap
// sequences. Instantiated with CNT_W=4 so the wrap is reachable quickly.
module tb_instr_reg_decode;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             ir_write;
  logic [XLEN-1:0]  mem_rdata;
  logic             illegal_clr;
  logic [XLEN-1:0]  mdr;
  logic [6:0]       op;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  imm;
  logic [2:0]       imm_fmt;
  logic             illegal;
  logic             illegal_sticky;
  logic [CNT_W-1:0] fetch_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  instr_reg_decode #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ir_write       (ir_write),
    .mem_rdata      (mem_rdata),
    .illegal_clr    (illegal_clr),
    .mdr            (mdr),
    .op             (op),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct3         (funct3),
    .funct7         (funct7),
    .imm            (imm),
    .imm_fmt        (imm_fmt),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample 1ns later
  task automatic cyc(input logic rst, input logic wr, input logic [31:0] data, input logic clr);
    @(negedge clk);
    reset       = rst;
    ir_write    = wr;
    mem_rdata   = data;
    illegal_clr = clr;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_cnt;
  logic        exp_sticky;
  logic        prev_ill;
  vec_t        last;

  initial begin
    reset = 1'b1; ir_write = 1'b1; mem_rdata = 32'hFFFF_FFFF; illegal_clr = 1'b0;

    //                instr          op        rd  rs1 rs2 f3 f7     imm           fmt ill
    vecs[0]  = '{32'hFFF1_0093, 7'h13, 5'd1,  5'd2,  5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h0053_2423, 7'h23, 5'd8,  5'd6,  5'd5,  3'd2, 7'h00, 32'h0000_0008, 3'd2, 1'b0};
    vecs[2]  = '{32'hFE00_0EE3, 7'h63, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFF_FFFC, 3'd3, 1'b0};
    vecs[3]  = '{32'h1234_52B7, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h1234_5000, 3'd4, 1'b0};
    vecs[4]  = '{32'h0010_00EF, 7'h6F, 5'd1,  5'd0,  5'd1,  3'd0, 7'h00, 32'h0000_0800, 3'd5, 1'b0};
    vecs[5]  = '{32'h0020_81B3, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0000, 3'd0, 1'b0};
    vecs[6]  = '{32'h8000_2003, 7'h03, 5'd0,  5'd0,  5'd0,  3'd2, 7'h40, 32'hFFFF_F800, 3'd1, 1'b0};
    vecs[7]  = '{32'h0000_0012, 7'h12, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0000, 3'd0, 1'b1};
    vecs[8]  = '{32'h0000_0073, 7'h73, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0000, 3'd1, 1'b0};
    vecs[9]  = '{32'hFFC0_8067, 7'h67, 5'd0,  5'd1,  5'd28, 3'd0, 7'h7F, 32'hFFFF_FFFC, 3'd1, 1'b0};
    vecs[10] = '{32'h0000_0000, 7'h00, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0000, 3'd0, 1'b1};
    vecs[11] = '{32'hFFFF_F517, 7'h17, 5'd10, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_F000, 3'd4, 1'b0};

    // Reset held two edges with ir_write=1 and an all-ones bus
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("rst_op",      {25'd0, op},        32'h0000_0013);
    chk("rst_imm",     imm,                32'h0);
    chk("rst_fmt",     {29'd0, imm_fmt},   32'd1);
    chk("rst_illegal", {31'd0, illegal},   32'd0);
    chk("rst_sticky",  {31'd0, illegal_sticky}, 32'd0);
    chk("rst_cnt",     {28'd0, fetch_cnt}, 32'd0);
    chk("rst_mdr",     mdr,                32'h0);
    chk("rst_fields",  {rd, rs1, rs2, funct3, funct7}, 32'h0);

    // Table: one IR load per vector, fields valid right after the load edge
    exp_cnt    = 0;
    exp_sticky = 1'b0;
    prev_ill   = 1'b0;
    for (int i = 0; i < NV; i++) begin
      cyc(1'b0, 1'b1, vecs[i].instr, 1'b0);
      exp_cnt    = (exp_cnt + 1) & 32'hF;
      exp_sticky = exp_sticky | prev_ill;
      prev_ill   = vecs[i].ill;
      chk($sformatf("v%0d_op", i),      {25'd0, op},      {25'd0, vecs[i].op});
      chk($sformatf("v%0d_rd", i),      {27'd0, rd},      {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_rs1", i),     {27'd0, rs1},     {27'd0, vecs[i].rs1});
      chk($sformatf("v%0d_rs2", i),     {27'd0, rs2},     {27'd0, vecs[i].rs2});
      chk($sformatf("v%0d_funct3", i),  {29'd0, funct3},  {29'd0, vecs[i].f3});
      chk($sformatf("v%0d_funct7", i),  {25'd0, funct7},  {25'd0, vecs[i].f7});
      chk($sformatf("v%0d_imm", i),     imm,              vecs[i].imm);
      chk($sformatf("v%0d_fmt", i),     {29'd0, imm_fmt}, {29'd0, vecs[i].fmt});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d_mdr", i),     mdr,              vecs[i].instr);
      chk($sformatf("v%0d_cnt", i),     {28'd0, fetch_cnt}, exp_cnt);
      chk($sformatf("v%0d_sticky", i),  {31'd0, illegal_sticky}, {31'd0, exp_sticky});
    end
    last = vecs[NV-1];

    // Hold: IR and counter frozen while MDR tracks the bus one cycle late
    cyc(1'b0, 1'b0, 32'hA5A5_A5A5, 1'b0);
    chk("hold1_mdr", mdr, 32'hA5A5_A5A5);
    chk("hold1_op",  {25'd0, op}, {25'd0, last.op});
    chk("hold1_imm", imm, last.imm);
    chk("hold1_cnt", {28'd0, fetch_cnt}, exp_cnt);
    @(negedge clk);
    mem_rdata = 32'h5A5A_5A5A;
    chk("hold2_mdr_before", mdr, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    chk("hold2_mdr",    mdr, 32'h5A5A_5A5A);
    chk("hold2_fields", {rd, rs1, rs2, funct3, funct7}, {last.rd, last.rs1, last.rs2, last.f3, last.f7});
    chk("hold2_cnt",    {28'd0, fetch_cnt}, exp_cnt);

    // Sticky: clear, load illegal, set-vs-clear collision, then clear
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stk_clr0", {31'd0, illegal_sticky}, 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0000, 1'b0);
    chk("stk_ill_now",   {31'd0, illegal},        32'd1);
    chk("stk_not_yet",   {31'd0, illegal_sticky}, 32'd0);
    chk("stk_ill_fmt",   {29'd0, imm_fmt},        32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0013, 1'b1);
    chk("stk_set_wins",  {31'd0, illegal_sticky}, 32'd1);
    chk("stk_legal_now", {31'd0, illegal},        32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stk_cleared",   {31'd0, illegal_sticky}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stk_stays_clr", {31'd0, illegal_sticky}, 32'd0);

    // Reset coinciding with ir_write: reset values, no count
    cyc(1'b1, 1'b1, 32'hFFF1_0093, 1'b0);
    chk("rstwr_cnt", {28'd0, fetch_cnt}, 32'd0);
    chk("rstwr_op",  {25'd0, op},        32'h0000_0013);
    chk("rstwr_mdr", mdr,                32'h0);

    // Counter wrap with a 4-bit counter over 17 back-to-back loads
    for (int k = 1; k <= 17; k++) begin
      cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0);
      if (k == 15) chk("wrap_15", {28'd0, fetch_cnt}, 32'd15);
      if (k == 16) chk("wrap_16", {28'd0, fetch_cnt}, 32'd0);
      if (k == 17) chk("wrap_17", {28'd0, fetch_cnt}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
